trena_uc_param: RTL and testbench
=================================

Name: trena_uc_param

Overview:
Parametrised control unit for the ultrasonic tape-measure (trena) system. It triggers a distance measurement and supervises it with a timeout. It then sends NUM_CHARS ASCII characters through the UART transmitter, one character at a time, by driving a character-select index. It supports single-shot operation and a continuous mode that re-measures after a programmable interval. It sits between the top-level trena datapath (sensor interface, character mux, UART TX) and the user inputs.

Parameters:
NUM_CHARS, 4, number of characters sent per measurement (2..16).
SEL_W, 2, width of seletor; must satisfy 2**SEL_W >= NUM_CHARS.
TIMEOUT_CYCLES, 50_000_000, maximum cycles spent in MEDE before an error is flagged (>=2).
INTERVALO_CYCLES, 25_000_000, wait in continuous mode between the end of a transmission and the next measurement (>=2).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
mensurar  in  1  start/restart request (level, sampled each cycle)
modo_continuo  in  1  1 = repeat measurements automatically
pronto_medida  in  1  sensor interface finished a measurement
pronto_transmissao  in  1  UART finished the current character
zera  out  1  clears datapath registers/counters
medir  out  1  keeps the sensor interface measuring
partida  out  1  one-cycle UART start pulse
seletor  out  SEL_W  character index for the character mux
pronto  out  1  measurement + transmission complete
erro_timeout  out  1  measurement timed out
db_estado  out  4  state code for debug display

Behaviour:
- Moore FSM. Outputs are decoded from the state register and the idx register. Every output changes one cycle after the causing input is sampled.
- State codes (db_estado): INICIAL 0x0, PREPARACAO 0x1, MEDE 0x2, ENVIA 0x3, AGUARDA 0x4, FINAL 0x5, ESPERA 0x6, ERRO 0xE. Any unused encoding shows 0xF on db_estado and goes to INICIAL on the next cycle.
- Reset: state=INICIAL, idx=0, both counters=0. Resulting outputs: zera=1, all other 1-bit outputs 0, seletor=0, db_estado=0x0. Reset mid-operation aborts immediately; no partial pulse is emitted after the reset cycle.
- INICIAL: zera=1. mensurar=1 -> PREPARACAO.
- PREPARACAO (1 cycle): zera=1; idx<=0; timeout counter<=0 -> MEDE.
- MEDE: medir=1; timeout counter increments.
  - pronto_medida=1 -> ENVIA. pronto_medida has priority over a timeout in the same cycle.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1 -> ERRO.
- ENVIA (1 cycle): partida=1; seletor=idx -> AGUARDA.
- AGUARDA: seletor=idx. On pronto_transmissao=1:
  - if idx==NUM_CHARS-1 -> FINAL;
  - else idx<=idx+1 -> ENVIA.
  - Exactly NUM_CHARS partida pulses per measurement, with seletor = 0,1,..,NUM_CHARS-1.
- FINAL: pronto=1.
  - mensurar=1 -> PREPARACAO (has priority).
  - else modo_continuo=1 -> ESPERA (interval counter<=0).
  - else stay in FINAL.
- ESPERA: pronto=1; interval counter increments.
  - modo_continuo=0 -> FINAL.
  - Counter reaches INTERVALO_CYCLES-1 -> PREPARACAO.
- ERRO: erro_timeout=1, sticky. mensurar=1 -> PREPARACAO; this clears the error. modo_continuo alone does not leave ERRO.
- seletor=0 in every state other than ENVIA/AGUARDA.
- pronto_transmissao outside AGUARDA and pronto_medida outside MEDE are ignored.
- Counters never wrap: they are cleared on entry and compared with ==.

Decomposition:
- Shared package trena_pkg: state encoding localparams and db_estado codes, shared with the datapath debug decoder.
- One sub-module, contador_m (modulo-M counter with clear, enable and end-of-count flag, parameter M). Instantiated twice: timeout (M=TIMEOUT_CYCLES) and interval (M=INTERVALO_CYCLES).

Test Plan (NUM_CHARS=4, TIMEOUT_CYCLES=20, INTERVALO_CYCLES=10):
1. Reset, then mensurar pulse; pronto_medida 5 cycles later; pronto_transmissao 3 cycles after each partida -> 4 partida pulses with seletor 0,1,2,3; then pronto=1, db_estado=0x5; zera high only in INICIAL/PREPARACAO.
2. mensurar pulse with pronto_medida never asserted -> exactly 20 cycles in MEDE, then erro_timeout=1, db_estado=0xE; stays there; a later mensurar -> PREPARACAO with erro_timeout=0.
3. pronto_medida asserted on the 20th MEDE cycle, the same cycle as the timeout -> ENVIA, erro_timeout stays 0.
4. modo_continuo=1 through two cycles -> after FINAL, 10 cycles in ESPERA then PREPARACAO; second transmission again has seletor 0..3; dropping modo_continuo during ESPERA -> FINAL.
5. reset asserted in AGUARDA with idx=2 -> next cycle INICIAL, seletor=0, partida=0; next transmission restarts at seletor=0.
6. Re-run with NUM_CHARS=6, SEL_W=3 -> 6 partida pulses, seletor 0..5, pronto only after the 6th pronto_transmissao.

Source files
------------

// File: rtl/trena_pkg.sv
// Shared state encoding for the trena control unit; db_estado codes are the
// state values themselves so the datapath debug decoder can reuse them.
package trena_pkg;

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    MEDE       = 4'h2,
    ENVIA      = 4'h3,
    AGUARDA    = 4'h4,
    FINAL      = 4'h5,
    ESPERA     = 4'h6,
    ERRO       = 4'hE
  } estado_t;

  localparam logic [3:0] DB_INVALIDO = 4'hF;

  function automatic logic [3:0] codigo_db(input estado_t e);
    case (e)
      INICIAL, PREPARACAO, MEDE, ENVIA,
      AGUARDA, FINAL, ESPERA, ERRO: codigo_db = 4'(e);
      default:                      codigo_db = DB_INVALIDO;
    endcase
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear/enable; fim flags the last count (M-1).
module contador_m #(
  parameter int M = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam int W = (M > 2) ? $clog2(M) : 1;
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] valor;

  always_ff @(posedge clock) begin
    if (reset || clear)
      valor <= '0;
    else if (enable)
      valor <= fim ? '0 : valor + 1'b1;
  end

  assign fim = (valor == ULTIMO);

endmodule

// File: rtl/trena_uc_param.sv
// Control unit for the ultrasonic tape measure: triggers a measurement with a
// timeout, then streams NUM_CHARS characters to the UART, optionally repeating.
module trena_uc_param
  import trena_pkg::*;
#(
  parameter int NUM_CHARS        = 4,
  parameter int SEL_W            = 2,
  parameter int TIMEOUT_CYCLES   = 50_000_000,
  parameter int INTERVALO_CYCLES = 25_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mensurar,
  input  logic             modo_continuo,
  input  logic             pronto_medida,
  input  logic             pronto_transmissao,
  output logic             zera,
  output logic             medir,
  output logic             partida,
  output logic [SEL_W-1:0] seletor,
  output logic             pronto,
  output logic             erro_timeout,
  output logic [3:0]       db_estado
);

  localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(NUM_CHARS - 1);

  estado_t          estado, proximo;
  logic [SEL_W-1:0] idx;
  logic             fim_timeout, fim_intervalo;

  always_ff @(posedge clock) begin
    if (reset)
      estado <= INICIAL;
    else
      estado <= proximo;
  end

  always_ff @(posedge clock) begin
    if (reset || estado == PREPARACAO)
      idx <= '0;
    else if (estado == AGUARDA && pronto_transmissao && idx != ULTIMO)
      idx <= idx + 1'b1;
  end

  // Both counters are cleared on the cycle before their supervised state begins.
  contador_m #(.M(TIMEOUT_CYCLES)) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (estado == PREPARACAO),
    .enable (estado == MEDE),
    .fim    (fim_timeout)
  );

  contador_m #(.M(INTERVALO_CYCLES)) u_intervalo (
    .clock  (clock),
    .reset  (reset),
    .clear  (estado == FINAL),
    .enable (estado == ESPERA),
    .fim    (fim_intervalo)
  );

  always_comb begin
    proximo      = INICIAL;
    zera         = 1'b0;
    medir        = 1'b0;
    partida      = 1'b0;
    pronto       = 1'b0;
    erro_timeout = 1'b0;
    seletor      = '0;
    db_estado    = codigo_db(estado);
    case (estado)
      INICIAL: begin
        zera    = 1'b1;
        proximo = mensurar ? PREPARACAO : INICIAL;
      end
      PREPARACAO: begin
        zera    = 1'b1;
        proximo = MEDE;
      end
      MEDE: begin
        medir = 1'b1;
        if (pronto_medida)    proximo = ENVIA;
        else if (fim_timeout) proximo = ERRO;
        else                  proximo = MEDE;
      end
      ENVIA: begin
        partida = 1'b1;
        seletor = idx;
        proximo = AGUARDA;
      end
      AGUARDA: begin
        seletor = idx;
        if (!pronto_transmissao) proximo = AGUARDA;
        else if (idx == ULTIMO)  proximo = FINAL;
        else                     proximo = ENVIA;
      end
      FINAL: begin
        pronto = 1'b1;
        if (mensurar)           proximo = PREPARACAO;
        else if (modo_continuo) proximo = ESPERA;
        else                    proximo = FINAL;
      end
      ESPERA: begin
        pronto = 1'b1;
        if (!modo_continuo)     proximo = FINAL;
        else if (fim_intervalo) proximo = PREPARACAO;
        else                    proximo = ESPERA;
      end
      ERRO: begin
        erro_timeout = 1'b1;
        proximo      = mensurar ? PREPARACAO : ERRO;
      end
      default: proximo = INICIAL;
    endcase
  end

endmodule

// File: tb/tb_trena_uc_param.sv
// Scoreboard bench for trena_uc_param: expected UART/pronto/erro events are
// queued by the stimulus and popped by an independent monitor.
module tb_trena_uc_param;

  localparam int NC = 4;
  localparam int TO = 20;
  localparam int IV = 10;

  typedef enum int {EV_PARTIDA = 0, EV_PRONTO = 1, EV_ERRO = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       valor;
  } evento_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mensurar = 1'b0, modo_continuo = 1'b0, pronto_medida = 1'b0;
  logic       pronto_transmissao;
  logic       pt_resp = 1'b0, pt_espurio = 1'b0;
  logic       zera, medir, partida, pronto, erro_timeout;
  logic [1:0] seletor;
  logic [3:0] db_estado;

  logic       m6 = 1'b0, pm6 = 1'b0, pt6 = 1'b0;
  logic       zera6, medir6, partida6, pronto6, erro6;
  logic [2:0] seletor6;
  logic [3:0] db6;

  evento_t esperado[$];
  int      checks = 0;
  int      passed = 0;
  int      bloqueia_sel = -1;

  assign pronto_transmissao = pt_resp | pt_espurio;

  always #5 clock = ~clock;

  trena_uc_param #(.NUM_CHARS(NC), .SEL_W(2), .TIMEOUT_CYCLES(TO), .INTERVALO_CYCLES(IV)) dut (
    .clock(clock), .reset(reset), .mensurar(mensurar), .modo_continuo(modo_continuo),
    .pronto_medida(pronto_medida), .pronto_transmissao(pronto_transmissao),
    .zera(zera), .medir(medir), .partida(partida), .seletor(seletor),
    .pronto(pronto), .erro_timeout(erro_timeout), .db_estado(db_estado)
  );

  trena_uc_param #(.NUM_CHARS(6), .SEL_W(3), .TIMEOUT_CYCLES(TO), .INTERVALO_CYCLES(IV)) dut6 (
    .clock(clock), .reset(reset), .mensurar(m6), .modo_continuo(1'b0),
    .pronto_medida(pm6), .pronto_transmissao(pt6),
    .zera(zera6), .medir(medir6), .partida(partida6), .seletor(seletor6),
    .pronto(pronto6), .erro_timeout(erro6), .db_estado(db6)
  );

  task automatic checkOutput(input string nome, input int atual, input int exigido);
    checks++;
    if (atual == exigido) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", nome, atual, exigido);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic observe(input ev_kind_t kind, input int valor);
    evento_t e;
    if (esperado.size() == 0) begin
      checkOutput("evento_inesperado", int'(kind), -1);
    end else begin
      e = esperado.pop_front();
      checkOutput("tipo_evento", int'(kind), int'(e.kind));
      if (e.kind == EV_PARTIDA && kind == EV_PARTIDA)
        checkOutput("seletor_partida", valor, e.valor);
    end
  endtask

  // Monitor: every partida pulse and each rising pronto/erro_timeout is an event.
  initial begin
    logic pronto_ant, erro_ant;
    pronto_ant = 1'b0;
    erro_ant   = 1'b0;
    forever begin
      @(negedge clock);
      if (partida === 1'b1) observe(EV_PARTIDA, int'(seletor));
      if (pronto === 1'b1 && !pronto_ant) observe(EV_PRONTO, 0);
      if (erro_timeout === 1'b1 && !erro_ant) observe(EV_ERRO, 0);
      pronto_ant = (pronto === 1'b1);
      erro_ant   = (erro_timeout === 1'b1);
    end
  end

  // UART model: answers each character after a random latency.
  initial begin
    int d;
    forever begin
      @(negedge clock);
      if (partida === 1'b1 && int'(seletor) != bloqueia_sel) begin
        d = $urandom_range(1, 5);
        repeat (d) @(posedge clock);
        #1 pt_resp = 1'b1;
        @(posedge clock);
        #1 pt_resp = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectTransmission();
    evento_t e;
    for (int k = 0; k < NC; k++) begin
      e.kind = EV_PARTIDA; e.valor = k;
      esperado.push_back(e);
    end
    e.kind = EV_PRONTO; e.valor = 0;
    esperado.push_back(e);
  endtask

  task automatic waitDb(input int codigo, input int limite, input string nome);
    int n = 0;
    while (int'(db_estado) != codigo && n < limite) begin
      tick();
      n++;
    end
    checkOutput(nome, int'(db_estado), codigo);
  endtask

  // Pulse mensurar and land on the first MEDE cycle.
  task automatic applyStimulus();
    mensurar = 1'b1;
    tick();
    checkOutput("db_preparacao", int'(db_estado), 1);
    checkOutput("zera_preparacao", int'(zera), 1);
    checkOutput("erro_preparacao", int'(erro_timeout), 0);
    mensurar = 1'b0;
    tick();
    checkOutput("db_mede", int'(db_estado), 2);
    checkOutput("medir_mede", int'(medir), 1);
    checkOutput("zera_mede", int'(zera), 0);
  endtask

  // From MEDE cycle 1, answer pronto_medida on MEDE cycle 'atraso'.
  task automatic measureAfter(input int atraso);
    expectTransmission();
    for (int c = 1; c < atraso; c++) begin
      if (c == 1) pt_espurio = 1'b1;
      tick();
      pt_espurio = 1'b0;
    end
    checkOutput("db_ainda_mede", int'(db_estado), 2);
    pronto_medida = 1'b1;
    tick();
    pronto_medida = 1'b0;
    checkOutput("db_envia", int'(db_estado), 3);
    checkOutput("erro_envia", int'(erro_timeout), 0);
  endtask

  initial begin
    evento_t e;
    int d;

    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset_db", int'(db_estado), 0);
    checkOutput("reset_zera", int'(zera), 1);
    checkOutput("reset_medir", int'(medir), 0);
    checkOutput("reset_partida", int'(partida), 0);
    checkOutput("reset_pronto", int'(pronto), 0);
    checkOutput("reset_erro", int'(erro_timeout), 0);
    checkOutput("reset_seletor", int'(seletor), 0);
    reset = 1'b0;
    tick();
    checkOutput("inicial_espera", int'(db_estado), 0);

    // Single-shot measurements with random sensor latency.
    for (int r = 0; r < 4; r++) begin
      applyStimulus();
      measureAfter((r == 0) ? 5 : int'($urandom_range(1, 19)));
      waitDb(5, 200, "fim_transmissao");
      checkOutput("pronto_final", int'(pronto), 1);
      checkOutput("seletor_final", int'(seletor), 0);
      checkOutput("zera_final", int'(zera), 0);
      pronto_medida = 1'b1;
      tick();
      pronto_medida = 1'b0;
      checkOutput("final_ignora_medida", int'(db_estado), 5);
    end

    // Timeout: exactly TO cycles in MEDE.
    e.kind = EV_ERRO; e.valor = 0;
    esperado.push_back(e);
    applyStimulus();
    repeat (TO - 1) tick();
    checkOutput("mede_ultimo_ciclo", int'(db_estado), 2);
    tick();
    checkOutput("db_erro", int'(db_estado), 14);
    checkOutput("erro_ativo", int'(erro_timeout), 1);
    checkOutput("medir_erro", int'(medir), 0);
    modo_continuo = 1'b1;
    repeat (5) tick();
    checkOutput("erro_pegajoso", int'(db_estado), 14);
    checkOutput("erro_continua", int'(erro_timeout), 1);
    modo_continuo = 1'b0;

    // Sensor answer on the same cycle as the timeout wins.
    applyStimulus();
    measureAfter(TO);
    waitDb(5, 200, "fim_pos_erro");

    // Continuous mode.
    expectTransmission();
    modo_continuo = 1'b1;
    tick();
    checkOutput("db_espera", int'(db_estado), 6);
    checkOutput("pronto_espera", int'(pronto), 1);
    repeat (IV - 1) tick();
    checkOutput("espera_ultimo_ciclo", int'(db_estado), 6);
    tick();
    checkOutput("espera_para_prep", int'(db_estado), 1);
    tick();
    checkOutput("continuo_mede", int'(db_estado), 2);
    void'(esperado.pop_back());
    repeat (NC) void'(esperado.pop_back());
    measureAfter($urandom_range(1, 10));
    waitDb(5, 200, "fim_continuo");
    tick();
    checkOutput("espera_de_novo", int'(db_estado), 6);
    repeat (3) tick();
    modo_continuo = 1'b0;
    tick();
    checkOutput("espera_cancelada", int'(db_estado), 5);
    checkOutput("pronto_cancelada", int'(pronto), 1);

    // Reset while waiting on character 2.
    bloqueia_sel = 2;
    applyStimulus();
    measureAfter(3);
    d = 0;
    while (!(int'(db_estado) == 4 && int'(seletor) == 2) && d < 100) begin
      tick();
      d++;
    end
    checkOutput("aguarda_idx2", int'(seletor), 2);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    esperado.delete();
    checkOutput("reset_meio_db", int'(db_estado), 0);
    checkOutput("reset_meio_seletor", int'(seletor), 0);
    checkOutput("reset_meio_partida", int'(partida), 0);
    reset = 1'b0;
    bloqueia_sel = -1;
    repeat (4) tick();
    checkOutput("pos_reset_inicial", int'(db_estado), 0);
    applyStimulus();
    measureAfter($urandom_range(1, 10));
    waitDb(5, 200, "fim_pos_reset");

    // Six-character instance.
    m6 = 1'b1;
    tick();
    m6 = 1'b0;
    tick();
    checkOutput("dut6_mede", int'(db6), 2);
    pm6 = 1'b1;
    tick();
    pm6 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checkOutput("dut6_partida", int'(partida6), 1);
      checkOutput("dut6_seletor", int'(seletor6), k);
      d = $urandom_range(0, 3);
      tick();
      repeat (d) tick();
      checkOutput("dut6_aguarda", int'(db6), 4);
      checkOutput("dut6_pronto_cedo", int'(pronto6), 0);
      pt6 = 1'b1;
      tick();
      pt6 = 1'b0;
    end
    checkOutput("dut6_final", int'(db6), 5);
    checkOutput("dut6_pronto", int'(pronto6), 1);

    repeat (3) tick();
    checkOutput("fila_vazia", esperado.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
